// File: rtl/block_ack_tx_pkg.sv
// Shared types for the bootloader acknowledgement transmitter: frame codes,
// serializer state encoding and the layout of a queued frame.
package ack_pkg;

    localparam logic [7:0] ACK_CODE = 8'h06;
    localparam logic [7:0] EOT_CODE = 8'h04;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] arg;
        logic [7:0] sum;
    } ack_frame_t;

endpackage

// File: rtl/block_ack_tx_if.sv
// Signal bundle between the loader core (master) and the acknowledgement
// transmitter (slave): received-byte tap, SPI completion pulses and line status.
interface block_ack_tx_if;

    logic       data_en;
    logic [7:0] data;
    logic       ack_req;
    logic       end_req;
    logic       tx;
    logic       busy;
    logic       overflow;

    modport master (
        output data_en, data, ack_req, end_req,
        input  tx, busy, overflow
    );

    modport slave (
        input  data_en, data, ack_req, end_req,
        output tx, busy, overflow
    );

endinterface

// File: rtl/uart_tx_byte.sv
// One-byte UART 8N1 serializer (START/DATA/STOP) with a load/ready handshake;
// a byte offered during the last STOP cycle follows with no idle gap.
module uart_tx_byte
    import ack_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       ready,
    output logic       tx,
    output tx_state_t  state
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_last;

    assign bit_last = (cnt == CNT_LAST);

    // Handshake: a byte transfers on any rising edge where load && ready.
    // ready depends only on internal state, never on load.
    assign ready = (state == TX_IDLE) || ((state == TX_STOP) && bit_last);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= TX_IDLE;
            tx      <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (load) begin
                        state <= TX_START;
                        tx    <= 1'b0;
                        cnt   <= '0;
                        shreg <= load_data;
                    end
                end
                TX_START: begin
                    if (bit_last) begin
                        state   <= TX_DATA;
                        tx      <= shreg[0];
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_last) begin
                        cnt   <= '0;
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= TX_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_last) begin
                        cnt <= '0;
                        if (load) begin
                            state <= TX_START;
                            tx    <= 1'b0;
                            shreg <= load_data;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/block_ack_tx.sv
// Block acknowledgement transmitter: queues ACK/EOT frames and sends them as
// 3-byte UART frames. BLOCK_ACK_CHECKSUM_EN compiles in the per-block checksum.
module block_ack_tx
    import ack_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           n_rst,
    block_ack_tx_if.slave  bus
);

    localparam int PW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNTW = PW + 1;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(QUEUE_DEPTH);

    ack_frame_t      queue_mem [QUEUE_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic [7:0]      blk_idx;
    logic [7:0]      blk_sum;
    logic            overflow_q;
    logic            push_ack;
    logic            push_eot;
    logic            pop;
    ack_frame_t      ack_frame;
    ack_frame_t      eot_frame;

    ack_frame_t      cur_frame;
    logic            active;
    logic [1:0]      byte_idx;
    logic [7:0]      ser_byte;
    logic            ser_ready;
    logic            ser_tx;
    tx_state_t       ser_state;

`ifdef BLOCK_ACK_CHECKSUM_EN
    logic [7:0] acc;

    // A byte strobed together with ack_req belongs to the block being acked.
    assign blk_sum = acc + (bus.data_en ? bus.data : 8'h00);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc <= 8'h00;
        end else if (bus.ack_req) begin
            acc <= 8'h00;
        end else if (bus.data_en) begin
            acc <= blk_sum;
        end
    end
`else
    logic unused_data;

    assign unused_data = ^{bus.data_en, bus.data};
    assign blk_sum     = 8'h00;
`endif

    // ACK takes the first free slot; EOT only fits if a second one remains.
    assign push_ack  = bus.ack_req && (count < DEPTH_C);
    assign push_eot  = bus.end_req && ((count + CNTW'(push_ack)) < DEPTH_C);
    assign pop       = !active && (count != '0) && ser_ready;
    assign ack_frame = '{code: ACK_CODE, arg: blk_idx, sum: blk_sum};
    assign eot_frame = '{code: EOT_CODE, arg: blk_idx + 8'(bus.ack_req), sum: 8'h00};

    always_ff @(posedge clk) begin
        if (push_ack) begin
            queue_mem[wr_ptr] <= ack_frame;
        end
        if (push_eot) begin
            queue_mem[wr_ptr + PW'(push_ack)] <= eot_frame;
        end
    end

    // Index advances on every ack_req, even when its frame is dropped.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            blk_idx    <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_ack) + PW'(push_eot);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CNTW'(push_ack) + CNTW'(push_eot) - CNTW'(pop);
            if (bus.ack_req) begin
                blk_idx <= blk_idx + 8'd1;
            end
            if ((bus.ack_req && !push_ack) || (bus.end_req && !push_eot)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Frame sequencer: pops while the serializer is idle or in its final STOP
    // cycle, which leaves exactly one idle-high cycle between frames.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cur_frame <= '0;
            active    <= 1'b0;
            byte_idx  <= 2'd0;
        end else if (pop) begin
            cur_frame <= queue_mem[rd_ptr];
            active    <= 1'b1;
            byte_idx  <= 2'd0;
        end else if (active && ser_ready) begin
            if (byte_idx == 2'd2) begin
                active <= 1'b0;
            end else begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    always_comb begin
        ser_byte = cur_frame.sum;
        case (byte_idx)
            2'd0:    ser_byte = cur_frame.code;
            2'd1:    ser_byte = cur_frame.arg;
            default: ser_byte = cur_frame.sum;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (active),
        .load_data (ser_byte),
        .ready     (ser_ready),
        .tx        (ser_tx),
        .state     (ser_state)
    );

    assign bus.tx       = ser_tx;
    assign bus.busy     = (count != '0) || active || (ser_state != TX_IDLE);
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_block_ack_tx.sv
// Bench for block_ack_tx: directed scenarios plus randomized traffic, checked
// by a UART line monitor against a frame/timing reference model.
module tb_block_ack_tx;

    localparam int CPB = 4;
    localparam int QD  = 4;
    localparam int FRAME_CYC = 30 * CPB;
`ifdef BLOCK_ACK_CHECKSUM_EN
    localparam bit CS_ON = 1'b1;
`else
    localparam bit CS_ON = 1'b0;
`endif
    localparam logic [7:0] SUM_SINGLE = CS_ON ? 8'h60 : 8'h00;
    localparam logic [7:0] SUM_SAME   = CS_ON ? 8'h01 : 8'h00;

    logic clk;
    logic n_rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   mon_en;
    bit   mon_in_byte;

    // reference model state
    logic [7:0] exp_q[$];
    int         exp_t[$];
    int         pops[$];
    logic [7:0] rx_log[$];
    logic [7:0] m_idx;
    logic [7:0] m_sum;
    logic       m_ovf;
    int         last_pop;

    block_ack_tx_if bus();

    block_ack_tx #(
        .CLKS_PER_BIT (CPB),
        .QUEUE_DEPTH  (QD)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // clock / reset / cycle count
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Each frame leaves the queue one cycle after it is enqueued, or the
    // cycle its predecessor's last stop bit ends, whichever is later; bytes
    // then follow every 10 bit times starting one cycle after the pop.
    function automatic void model_push(input int t, input logic [7:0] c,
                                       input logic [7:0] a, input logic [7:0] s);
        int p;
        while (pops.size() > 0 && pops[0] < t) void'(pops.pop_front());
        if (pops.size() >= QD) begin
            m_ovf = 1'b1;
            return;
        end
        p = t + 1;
        if (last_pop + FRAME_CYC + 1 > p) p = last_pop + FRAME_CYC + 1;
        last_pop = p;
        pops.push_back(p);
        exp_q.push_back(c); exp_t.push_back(p + 1);
        exp_q.push_back(a); exp_t.push_back(p + 1 + 10 * CPB);
        exp_q.push_back(s); exp_t.push_back(p + 1 + 20 * CPB);
    endfunction

    function automatic void model_edge(input int t, input logic a, input logic e,
                                       input logic de, input logic [7:0] d);
        logic [7:0] s;
        s = m_sum + ((de && CS_ON) ? d : 8'h00);
        if (a) begin
            model_push(t, 8'h06, m_idx, s);
            m_idx = m_idx + 8'd1;
            m_sum = 8'h00;
        end else begin
            m_sum = s;
        end
        if (e) model_push(t, 8'h04, m_idx, 8'h00);
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        exp_t.delete();
        pops.delete();
        rx_log.delete();
        m_idx    = 8'h00;
        m_sum    = 8'h00;
        m_ovf    = 1'b0;
        last_pop = -100000;
    endfunction

    // line monitor / scoreboard
    initial begin : monitor
        int         fall;
        logic [7:0] b;
        logic       stop_ok;
        logic [7:0] e;
        int         et;
        mon_in_byte = 1'b0;
        forever begin
            @(negedge clk);
            if (n_rst && bus.tx == 1'b0) begin
                fall = cyc;
                mon_in_byte = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = bus.tx;
                end
                repeat (CPB) @(negedge clk);
                stop_ok = bus.tx;
                if (mon_en) begin
                    rx_log.push_back(b);
                    check("stop_bit", 32'(stop_ok), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("bytes_pending", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e  = exp_q.pop_front();
                        et = exp_t.pop_front();
                        check("byte_value", 32'(b), 32'(e));
                        check("byte_start_cycle", 32'(fall), 32'(et));
                    end
                end
                mon_in_byte = 1'b0;
            end
        end
    end

    // driver tasks (called on a falling edge)
    task automatic step(input logic a, input logic e, input logic de, input logic [7:0] d);
        bus.ack_req = a;
        bus.end_req = e;
        bus.data_en = de;
        bus.data    = d;
        model_edge(cyc + 1, a, e, de, d);
        @(negedge clk);
        bus.ack_req = 1'b0;
        bus.end_req = 1'b0;
        bus.data_en = 1'b0;
        bus.data    = 8'h00;
    endtask

    task automatic do_reset();
        int n;
        n = 0;
        mon_en = 1'b0;
        #1 n_rst = 1'b0;
        while (mon_in_byte && n < 100) begin
            @(negedge clk);
            n++;
        end
        model_clear();
        repeat (2) @(negedge clk);
        n_rst  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 5000), 32'd1);
        check("busy_fall_cycle", 32'(cyc), 32'(last_pop + 1 + FRAME_CYC));
        check("exp_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] c, input logic [7:0] a,
                               input logic [7:0] s, input bit chk_sum);
        logic [7:0] b0, b1, b2;
        check({tag, "_len"}, 32'(rx_log.size() >= 3), 32'd1);
        if (rx_log.size() >= 3) begin
            b0 = rx_log.pop_front();
            b1 = rx_log.pop_front();
            b2 = rx_log.pop_front();
            check({tag, "_code"}, 32'(b0), 32'(c));
            check({tag, "_arg"}, 32'(b1), 32'(a));
            if (chk_sum) check({tag, "_sum"}, 32'(b2), 32'(s));
        end
    endtask

    initial begin : main
        int t_ack;
        int nd;
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        n_rst    = 1'b0;
        bus.ack_req = 1'b0;
        bus.end_req = 1'b0;
        bus.data_en = 1'b0;
        bus.data    = 8'h00;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        n_rst  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // single block
        step(1'b0, 1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b0, 1'b1, 8'h20);
        step(1'b0, 1'b0, 1'b1, 8'h30);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        t_ack = cyc;
        check("busy_rise", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("tx_high_n1", 32'(bus.tx), 32'd1);
        @(negedge clk);
        check("tx_low_n2", 32'(bus.tx), 32'd0);
        wait_idle();
        check("frame_cycles", 32'(cyc - (t_ack + 2)), 32'(FRAME_CYC));
        check("single_busy_low", 32'(bus.busy), 32'd0);
        check_frame("single", 8'h06, 8'h00, SUM_SINGLE, 1'b1);

        // byte strobed with ack_req, then an empty block
        do_reset();
        step(1'b0, 1'b0, 1'b1, 8'h02);
        step(1'b1, 1'b0, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        wait_idle();
        check_frame("same_cyc", 8'h06, 8'h00, SUM_SAME, 1'b1);
        check_frame("next_blk", 8'h06, 8'h01, 8'h00, 1'b1);

        // end of image
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
            step(1'b1, 1'b0, 1'b0, 8'h00);
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        wait_idle();
        check_frame("eot_a0", 8'h06, 8'h00, 8'h00, 1'b0);
        check_frame("eot_a1", 8'h06, 8'h01, 8'h00, 1'b0);
        check_frame("eot_a2", 8'h06, 8'h02, 8'h00, 1'b0);
        check_frame("eot", 8'h04, 8'h03, 8'h00, 1'b1);
        check("eot_overflow", 32'(bus.overflow), 32'd0);

        // same-cycle ack_req and end_req
        do_reset();
        step(1'b1, 1'b1, 1'b0, 8'h00);
        wait_idle();
        check_frame("both_ack", 8'h06, 8'h00, 8'h00, 1'b1);
        check_frame("both_eot", 8'h04, 8'h01, 8'h00, 1'b1);

        // overflow by consecutive requests
        do_reset();
        repeat (6) step(1'b1, 1'b0, 1'b0, 8'h00);
        wait_idle();
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("ovf_model", 32'(bus.overflow), 32'(m_ovf));
        check("ovf_frames", 32'(rx_log.size()), 32'd15);
        for (int k = 0; k < 5; k++) check_frame("ovf_idx", 8'h06, 8'(k), 8'h00, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        wait_idle();
        check_frame("ovf_after", 8'h06, 8'h06, 8'h00, 1'b1);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // one slot left for a same-cycle ack_req/end_req pair
        do_reset();
        repeat (4) step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        wait_idle();
        check("slot_overflow", 32'(bus.overflow), 32'd1);
        check("slot_frames", 32'(rx_log.size()), 32'd15);

        // index wrap: 257 blocks with random payload
        do_reset();
        for (int k = 0; k < 257; k++) begin
            nd = $urandom_range(0, 3);
            for (int j = 0; j < nd; j++) step(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
            step(1'b1, 1'b0, 1'b0, 8'h00);
            if (k < 256) repeat (FRAME_CYC) @(negedge clk);
        end
        wait_idle();
        check("wrap_frames", 32'(rx_log.size()), 32'd771);
        if (rx_log.size() == 771) begin
            check("wrap_code", 32'(rx_log[768]), 32'h06);
            check("wrap_index", 32'(rx_log[769]), 32'h00);
        end
        check("wrap_overflow", 32'(bus.overflow), 32'd0);

        // reset in the middle of a data bit
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (2 + CPB + 2) @(negedge clk);
        mon_en = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check("midrst_tx", 32'(bus.tx), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_overflow", 32'(bus.overflow), 32'd0);
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        wait_idle();
        check_frame("post_rst", 8'h06, 8'h00, 8'h00, 1'b1);

        // randomized traffic
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 1500; k++) begin
            step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)));
        end
        wait_idle();
        check("rand_overflow", 32'(bus.overflow), 32'(m_ovf));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
